// File: rtl/iram_loader_pkg.sv
// Shared types and helpers for the UART-to-instruction-RAM loader.
package iram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic logic [31:0] le_word_insert(
        input logic [31:0] word,
        input logic [7:0]  b,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/iram_uart_loader.sv
// Loads a framed UART byte stream into instruction RAM as LE 32-bit words.
// Define IRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module iram_uart_loader
    import iram_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic [3:0]  imem_we,
    output logic        imem_en,
    output logic        prog_ena,
    output logic        state_load_prog,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    loader_state_t state_q, state_d;
    logic          prog_ena_q, prog_ena_d;
    logic          load_err_q, load_err_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          wr_pend_q, wr_pend_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic [31:0] asm_word;
    logic [15:0] len_full;
    logic        active;

    assign asm_word = le_word_insert(word_q, rx_data, byte_idx_q);
    assign len_full = {rx_data, len_q[7:0]};
    assign active   = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);

    always_comb begin
        state_d    = state_q;
        prog_ena_d = prog_ena_q;
        load_err_d = load_err_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        tmo_d      = '0;
        wr_pend_d  = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = LEN0;
                    prog_ena_d = 1'b1;
                    load_err_d = 1'b0;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            LEN0: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (rx_valid) begin
                    len_d      = len_full;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (len_full == 16'h0000)
                        state_d = DONE;
                    else if (32'(len_full) > DEPTH_WORDS)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    word_d     = asm_word;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        // Write lands next cycle, alongside the next byte or DONE/CSUM.
                        wr_pend_d  = 1'b1;
                        wr_addr_d  = BASE_ADDR + {14'h0, word_idx_q, 2'b00};
                        wr_data_d  = asm_word;
                        word_d     = '0;
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
`ifdef IRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid)
                    state_d = (rx_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                state_d    = IDLE;
                prog_ena_d = 1'b0;
            end
            ERR: begin
                state_d    = IDLE;
                prog_ena_d = 1'b0;
                load_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (active && !rx_valid) begin
            if (tmo_q == TMO_LAST)
                state_d = ERR;
            else
                tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            prog_ena_q <= 1'b0;
            load_err_q <= 1'b0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tmo_q      <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prog_ena_q <= prog_ena_d;
            load_err_q <= load_err_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            tmo_q      <= tmo_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_en         = wr_pend_q;
    assign imem_we         = {4{wr_pend_q}};
    assign imem_addr       = wr_addr_q;
    assign imem_din        = wr_data_q;
    assign prog_ena        = prog_ena_q;
    assign load_err        = load_err_q;
    assign load_done       = (state_q == DONE);
    assign state_load_prog = (state_q == DATA);

endmodule

// File: tb/tb_iram_uart_loader.sv
// Directed plus randomized frame bench for iram_uart_loader.
// Honours IRAM_LOADER_CHECKSUM_EN to append and test checksum bytes.
module tb_iram_uart_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic [3:0]  imem_we;
    logic        imem_en;
    logic        prog_ena;
    logic        state_load_prog;
    logic        load_done;
    logic        load_err;

    iram_uart_loader #(
        .BASE_ADDR(32'h0000_0000),
        .DEPTH_WORDS(1024),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .imem_addr(imem_addr),
        .imem_din(imem_din),
        .imem_we(imem_we),
        .imem_en(imem_en),
        .prog_ena(prog_ena),
        .state_load_prog(state_load_prog),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cyc = 0;
    logic [31:0] mon_a[$];
    logic [31:0] mon_d[$];
    logic [3:0]  mon_we[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [7:0]  frame[$];

    always @(negedge clk) begin
        if (imem_en) begin
            mon_a.push_back(imem_addr);
            mon_d.push_back(imem_din);
            mon_we.push_back(imem_we);
        end
        if (load_done) done_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_a.delete();
        mon_d.delete();
        mon_we.delete();
        done_cyc = 0;
    endtask

    // Reference: words are 4 LE bytes after the 3-byte header, addr = 4*k.
    task automatic build_exp();
        int n;
        exp_a.delete();
        exp_d.delete();
        n = int'(frame[1]) + 256 * int'(frame[2]);
        if (n >= 1 && n <= 1024) begin
            for (int k = 0; k < n; k++) begin
                exp_a.push_back(32'(4 * k));
                exp_d.push_back({frame[3+4*k+3], frame[3+4*k+2],
                                 frame[3+4*k+1], frame[3+4*k]});
            end
        end
    endtask

    task automatic make_frame(input int n);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame.push_back(b);
        end
`ifdef IRAM_LOADER_CHECKSUM_EN
        frame.push_back(x);
`endif
    endtask

    task automatic send_frame(input int maxgap);
        for (int i = 0; i < frame.size(); i++) begin
            send(frame[i]);
            if (maxgap > 0 && i != frame.size() - 1)
                idle($urandom_range(maxgap, 0));
        end
    endtask

    task automatic check_writes(input string tag);
        int m;
        check({tag, " nwrites"}, 32'(mon_a.size()), 32'(exp_a.size()));
        m = (mon_a.size() < exp_a.size()) ? mon_a.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s addr%0d", tag, i), mon_a[i], exp_a[i]);
            check($sformatf("%s data%0d", tag, i), mon_d[i], exp_d[i]);
            check($sformatf("%s we%0d", tag, i), 32'(mon_we[i]), 32'hF);
        end
    endtask

    initial begin
        logic [7:0] g;
        @(negedge clk);
        idle(2);
        check("rst imem_en", 32'(imem_en), 0);
        check("rst imem_we", 32'(imem_we), 0);
        check("rst imem_addr", imem_addr, 0);
        check("rst imem_din", imem_din, 0);
        check("rst prog_ena", 32'(prog_ena), 0);
        check("rst load_prog", 32'(state_load_prog), 0);
        check("rst load_done", 32'(load_done), 0);
        check("rst load_err", 32'(load_err), 0);
        Rst = 1'b1;
        idle(2);

        // Two-word frame, back-to-back bytes
        clear_mon();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IRAM_LOADER_CHECKSUM_EN
        frame.push_back(8'h13 ^ 8'h93 ^ 8'h10);
`endif
        build_exp();
        send(frame[0]);
        check("A prog_ena after sync", 32'(prog_ena), 1);
        send(frame[1]);
        send(frame[2]);
        check("A load_prog in data", 32'(state_load_prog), 1);
        for (int i = 3; i < frame.size(); i++) send(frame[i]);
        idle(3);
        check_writes("A");
        check("A done pulses", 32'(done_cyc), 1);
        check("A prog_ena end", 32'(prog_ena), 0);
        check("A load_err", 32'(load_err), 0);

        // Zero-length frame
        clear_mon();
        send(8'hA5); send(8'h00); send(8'h00);
        check("N0 load_done", 32'(load_done), 1);
        check("N0 prog_ena in done", 32'(prog_ena), 1);
        idle(1);
        check("N0 load_done drop", 32'(load_done), 0);
        check("N0 prog_ena end", 32'(prog_ena), 0);
        check("N0 load_err", 32'(load_err), 0);
        check("N0 nwrites", 32'(mon_a.size()), 0);

        // Oversize length
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h04);
        check("big err in ERR cycle", 32'(load_err), 0);
        check("big prog_ena in ERR", 32'(prog_ena), 1);
        idle(1);
        check("big load_err", 32'(load_err), 1);
        check("big prog_ena end", 32'(prog_ena), 0);
        check("big nwrites", 32'(mon_a.size()), 0);
        check("big done", 32'(done_cyc), 0);

        // Timeout with a partial word
        clear_mon();
        send(8'hA5);
        check("tmo sync clears err", 32'(load_err), 0);
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        idle(TMO - 10);
        check("tmo not early", 32'(load_err), 0);
        check("tmo prog_ena held", 32'(prog_ena), 1);
        for (int i = 0; i < 3 * TMO && !load_err; i++) @(negedge clk);
        check("tmo load_err", 32'(load_err), 1);
        check("tmo prog_ena", 32'(prog_ena), 0);
        check("tmo nwrites", 32'(mon_a.size()), 0);
        clear_mon();
        make_frame(1);
        build_exp();
        send(frame[0]);
        check("tmo err cleared by sync", 32'(load_err), 0);
        for (int i = 1; i < frame.size(); i++) send(frame[i]);
        idle(3);
        check_writes("tmo recover");
        check("tmo recover done", 32'(done_cyc), 1);

        // Random frames with leading junk and gaps
        for (int f = 0; f < 8; f++) begin
            clear_mon();
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send(g);
            end
            make_frame($urandom_range(6, 1));
            build_exp();
            send_frame(3);
            idle(4);
            check_writes($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d done", f), 32'(done_cyc), 1);
            check($sformatf("rnd%0d err", f), 32'(load_err), 0);
            check($sformatf("rnd%0d prog_ena", f), 32'(prog_ena), 0);
        end

        // Full-depth frame
        clear_mon();
        make_frame(1024);
        build_exp();
        send_frame(0);
        idle(3);
        check_writes("full");
        check("full done", 32'(done_cyc), 1);
        check("full err", 32'(load_err), 0);

        // Reset in the middle of word 1
        clear_mon();
        make_frame(2);
        build_exp();
        for (int i = 0; i < 9; i++) send(frame[i]);
        idle(1);
        #2 Rst = 1'b0;
        #1;
        check("rst mid imem_en", 32'(imem_en), 0);
        check("rst mid prog_ena", 32'(prog_ena), 0);
        check("rst mid load_prog", 32'(state_load_prog), 0);
        check("rst mid addr", imem_addr, 0);
        check("rst mid din", imem_din, 0);
        check("rst mid we", 32'(imem_we), 0);
        @(negedge clk);
        Rst = 1'b1;
        repeat (4) send(8'h55);
        idle(2);
        check("rst mid nwrites", 32'(mon_a.size()), 1);
        if (mon_a.size() > 0) check("rst mid word0", mon_d[0], exp_d[0]);
        check("rst 55 prog_ena", 32'(prog_ena), 0);
        check("rst 55 load_prog", 32'(state_load_prog), 0);

`ifdef IRAM_LOADER_CHECKSUM_EN
        clear_mon();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        build_exp();
        send_frame(0);
        idle(3);
        check_writes("csum ok");
        check("csum ok done", 32'(done_cyc), 1);
        check("csum ok err", 32'(load_err), 0);
        clear_mon();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        build_exp();
        send_frame(0);
        idle(3);
        check_writes("csum bad");
        check("csum bad done", 32'(done_cyc), 0);
        check("csum bad err", 32'(load_err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
